dm_port_arbiter: RTL and testbench

- Shares one synchronous single-port data memory between two requesters.
- Port C is the CPU M-stage data access. Port D is a DMA/debug loader.
- Fixed priority to C, with a starvation guard and bounded locked bursts for D.
- Sits between CPU m_data_* bus and the DM bank; C's gnt drives the CPU pipeline stall.

---
 rtl/dm_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_dm_port_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/dm_port_arbiter.sv
// Two-port arbiter for a single-port data memory: CPU port C has priority, DMA port D gets starvation relief and locked bursts.
// Optional statistics counters are built when ARB_STATS_EN is defined.
module dm_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int MAX_BURST    = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic [3:0]        c_byteen,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [31:0]       c_wdata,
  output logic              c_gnt,
  output logic [31:0]       c_rdata,
  output logic              c_rvalid,
  input  logic              d_req,
  input  logic [3:0]        d_byteen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic              d_lock,
  output logic              d_gnt,
  output logic [31:0]       d_rdata,
  output logic              d_rvalid,
  output logic              m_en,
  output logic [3:0]        m_byteen,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
`ifdef ARB_STATS_EN
  output logic [31:0]       stat_c_cnt,
  output logic [31:0]       stat_d_cnt,
  output logic [31:0]       stat_conflict_cnt,
`endif
  input  logic [31:0]       m_rdata
);

  // state | meaning
  // IDLE  | no owner
  // OWN_C | last grant went to C
  // OWN_D | D holds a locked burst, C is refused
  typedef enum logic [1:0] {IDLE, OWN_C, OWN_D} state_t;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic BURST_OK = (MAX_BURST > 1);

  state_t          state_q, state_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic            c_prio_q, c_prio_d;
  logic            c_tag_q, d_tag_q;
  logic            c_win, d_win;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      starve_q <= '0;
      burst_q  <= '0;
      c_prio_q <= 1'b0;
      c_tag_q  <= 1'b0;
      d_tag_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      burst_q  <= burst_d;
      c_prio_q <= c_prio_d;
      c_tag_q  <= c_gnt && (c_byteen == 4'b0000);
      d_tag_q  <= d_gnt && (d_byteen == 4'b0000);
    end
  end

  always_comb begin
    state_d  = state_q;
    burst_d  = burst_q;
    c_prio_d = c_prio_q;
    c_win    = 1'b0;
    d_win    = 1'b0;
    case (state_q)
      OWN_D: begin
        if (d_req) begin
          d_win   = 1'b1;
          burst_d = burst_q + BW'(1);
          if (burst_q == BW'(MAX_BURST - 1)) begin
            // forced release: C must win the very next conflict
            state_d  = IDLE;
            burst_d  = '0;
            c_prio_d = 1'b1;
          end else if (!d_lock) begin
            state_d = IDLE;
            burst_d = '0;
          end
        end else begin
          state_d = IDLE;
          burst_d = '0;
        end
      end
      default: begin
        if (c_req && d_req) begin
          c_prio_d = 1'b0;
          if (starve_q == SW'(STARVE_LIMIT) && !c_prio_q) d_win = 1'b1;
          else                                            c_win = 1'b1;
        end else if (c_req) begin
          c_win = 1'b1;
        end else if (d_req) begin
          d_win = 1'b1;
        end
        if (c_win) begin
          state_d = OWN_C;
        end else if (d_win && d_lock && BURST_OK) begin
          state_d = OWN_D;
          burst_d = BW'(1);
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (d_win)                                       starve_d = '0;
    else if (d_req && starve_q != SW'(STARVE_LIMIT)) starve_d = starve_q + SW'(1);
  end

  // grants are held off while reset is asserted so the memory sees no access
  assign c_gnt = c_win & reset;
  assign d_gnt = d_win & reset;

  assign m_en     = c_gnt | d_gnt;
  assign m_byteen = c_gnt ? c_byteen : (d_gnt ? d_byteen : 4'b0000);
  assign m_addr   = c_gnt ? c_addr   : (d_gnt ? d_addr   : '0);
  assign m_wdata  = c_gnt ? c_wdata  : (d_gnt ? d_wdata  : 32'h0);

  assign c_rdata  = m_rdata;
  assign d_rdata  = m_rdata;
  assign c_rvalid = c_tag_q;
  assign d_rvalid = d_tag_q;

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_c_cnt        <= '0;
      stat_d_cnt        <= '0;
      stat_conflict_cnt <= '0;
    end else begin
      if (c_gnt)          stat_c_cnt        <= stat_c_cnt + 32'd1;
      if (d_gnt)          stat_d_cnt        <= stat_d_cnt + 32'd1;
      if (c_req && d_req) stat_conflict_cnt <= stat_conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Self-checking bench for dm_port_arbiter: vector table, read-return scoreboard, reset and stats sequences.
module tb_dm_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_req, d_req, d_lock;
  logic [3:0]  c_byteen, d_byteen;
  logic [31:0] c_addr, d_addr, c_wdata, d_wdata;
  logic        c_gnt, c_rvalid, d_gnt, d_rvalid, m_en;
  logic [31:0] c_rdata, d_rdata, m_addr, m_wdata;
  logic [3:0]  m_byteen;
  logic [31:0] m_rdata = 32'h0;
`ifdef ARB_STATS_EN
  logic [31:0] stat_c_cnt, stat_d_cnt, stat_conflict_cnt;
`endif

  dm_port_arbiter dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_byteen(c_byteen), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rdata(c_rdata), .c_rvalid(c_rvalid),
    .d_req(d_req), .d_byteen(d_byteen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_lock(d_lock), .d_gnt(d_gnt), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
    .m_en(m_en), .m_byteen(m_byteen), .m_addr(m_addr), .m_wdata(m_wdata),
`ifdef ARB_STATS_EN
    .stat_c_cnt(stat_c_cnt), .stat_d_cnt(stat_d_cnt), .stat_conflict_cnt(stat_conflict_cnt),
`endif
    .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h3000) ? 32'hDEADBEEF : (a ^ 32'hA5A5_0000);
  endfunction

  // synchronous single-port memory: read data one cycle after a read access
  always @(posedge clk) if (m_en && m_byteen == 4'b0000) m_rdata <= mem_f(m_addr);

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic c_req; logic [3:0] c_be; logic [31:0] c_addr; logic [31:0] c_wd;
    logic d_req; logic [3:0] d_be; logic [31:0] d_addr; logic [31:0] d_wd;
    logic d_lock; logic ec; logic ed;
  } vec_t;

  typedef struct { int due; bit port; logic [31:0] data; } rd_t;
  rd_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic cr, input logic [3:0] cb, input logic [31:0] ca,
                              input logic [31:0] cw, input logic dr, input logic [3:0] db,
                              input logic [31:0] da, input logic [31:0] dw, input logic dl,
                              input logic ec, input logic ed);
    vec_t v;
    v.c_req = cr; v.c_be = cb; v.c_addr = ca; v.c_wd = cw;
    v.d_req = dr; v.d_be = db; v.d_addr = da; v.d_wd = dw;
    v.d_lock = dl; v.ec = ec; v.ed = ed;
    return v;
  endfunction

  task automatic check_rvalid();
    logic exp_c, exp_d;
    while (sb.size() > 0 && sb[0].due < cyc) begin
      checks++; errors++;
      $display("FAIL rvalid_missing: read due cycle %0d never returned", sb[0].due);
      void'(sb.pop_front());
    end
    exp_c = (sb.size() > 0) && (sb[0].due == cyc) && !sb[0].port;
    exp_d = (sb.size() > 0) && (sb[0].due == cyc) &&  sb[0].port;
    chk("c_rvalid", {31'b0, c_rvalid}, {31'b0, exp_c});
    chk("d_rvalid", {31'b0, d_rvalid}, {31'b0, exp_d});
    if (exp_c) chk("c_rdata", c_rdata, sb[0].data);
    if (exp_d) chk("d_rdata", d_rdata, sb[0].data);
    if (exp_c || exp_d) void'(sb.pop_front());
  endtask

  // drive one cycle, check grants / memory mux / read return, queue expected reads
  task automatic apply(input vec_t v);
    logic [3:0]  eb;
    logic [31:0] ea, ew;
    c_req = v.c_req; c_byteen = v.c_be; c_addr = v.c_addr; c_wdata = v.c_wd;
    d_req = v.d_req; d_byteen = v.d_be; d_addr = v.d_addr; d_wdata = v.d_wd;
    d_lock = v.d_lock;
    #3;
    eb = v.ec ? v.c_be   : (v.ed ? v.d_be   : 4'b0);
    ea = v.ec ? v.c_addr : (v.ed ? v.d_addr : 32'h0);
    ew = v.ec ? v.c_wd   : (v.ed ? v.d_wd   : 32'h0);
    chk("c_gnt",    {31'b0, c_gnt}, {31'b0, v.ec});
    chk("d_gnt",    {31'b0, d_gnt}, {31'b0, v.ed});
    chk("m_en",     {31'b0, m_en},  {31'b0, v.ec | v.ed});
    chk("m_byteen", {28'b0, m_byteen}, {28'b0, eb});
    chk("m_addr",   m_addr, ea);
    chk("m_wdata",  m_wdata, ew);
    check_rvalid();
    if (v.ec && v.c_be == 4'b0) sb.push_back('{due: cyc + 1, port: 1'b0, data: mem_f(v.c_addr)});
    if (v.ed && v.d_be == 4'b0) sb.push_back('{due: cyc + 1, port: 1'b1, data: mem_f(v.d_addr)});
    @(posedge clk); #1;
  endtask

  vec_t tbl[20];
  vec_t idle;

  initial begin
    idle = mk(0,4'h0,32'h0,32'h0, 0,4'h0,32'h0,32'h0, 0, 0,0);
    //              c_req be   addr        wdata          d_req be addr        wdata      lk  ec ed
    tbl[0]  = mk(1,4'h0,32'h3000,32'h0,        0,4'h0,32'h0,  32'h0,   0, 1,0);
    tbl[1]  = idle;
    tbl[2]  = mk(1,4'h3,32'h0040,32'h12345678, 0,4'h0,32'h0,  32'h0,   0, 1,0);
    tbl[3]  = mk(0,4'h0,32'h0,   32'h0,        1,4'h0,32'h100,32'h0,   0, 0,1);
    tbl[4]  = mk(1,4'h0,32'h0200,32'h0,        1,4'h0,32'h300,32'h0,   0, 1,0);
    tbl[5]  = mk(1,4'h0,32'h0204,32'h0,        1,4'h0,32'h300,32'h0,   0, 1,0);
    tbl[6]  = mk(1,4'h0,32'h0208,32'h0,        1,4'h0,32'h300,32'h0,   0, 1,0);
    tbl[7]  = mk(1,4'h0,32'h020C,32'h0,        1,4'h0,32'h300,32'h0,   0, 0,1);
    tbl[8]  = mk(1,4'h0,32'h020C,32'h0,        1,4'h0,32'h304,32'h0,   0, 1,0);
    tbl[9]  = mk(0,4'h0,32'h0,   32'h0,        1,4'h0,32'h304,32'h0,   0, 0,1);
    tbl[10] = idle;
    tbl[11] = mk(0,4'h0,32'h0,   32'h0,        1,4'hF,32'h400,32'hA0,  1, 0,1);
    tbl[12] = mk(0,4'h0,32'h0,   32'h0,        1,4'hF,32'h401,32'hA1,  1, 0,1);
    tbl[13] = mk(0,4'h0,32'h0,   32'h0,        1,4'hF,32'h402,32'hA2,  1, 0,1);
    tbl[14] = mk(0,4'h0,32'h0,   32'h0,        1,4'hF,32'h403,32'hA3,  1, 0,1);
    tbl[15] = mk(1,4'h0,32'h0500,32'h0,        1,4'hF,32'h404,32'hA4,  1, 1,0);
    tbl[16] = mk(0,4'h0,32'h0,   32'h0,        1,4'hF,32'h404,32'hA4,  1, 0,1);
    tbl[17] = mk(1,4'h0,32'h0504,32'h0,        1,4'hF,32'h405,32'hA5,  0, 0,1);
    tbl[18] = mk(1,4'h0,32'h0504,32'h0,        0,4'h0,32'h0,  32'h0,   0, 1,0);
    tbl[19] = idle;

    reset = 1'b0;
    c_req = 1'b1; c_byteen = 4'h0; c_addr = 32'h10; c_wdata = 32'h0;
    d_req = 1'b0; d_byteen = 4'h0; d_addr = 32'h0;  d_wdata = 32'h0; d_lock = 1'b0;
    #12;
    chk("reset_c_gnt",    {31'b0, c_gnt},    32'h0);
    chk("reset_m_en",     {31'b0, m_en},     32'h0);
    chk("reset_c_rvalid", {31'b0, c_rvalid}, 32'h0);
    chk("reset_d_rvalid", {31'b0, d_rvalid}, 32'h0);
    c_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < 20; i++) apply(tbl[i]);
    chk("sb_drained", sb.size(), 32'd0);

    // reset during a locked D burst with a read in flight
    apply(mk(0,4'h0,32'h0,32'h0, 1,4'h0,32'h600,32'h0, 1, 0,1));
    void'(sb.pop_back());
    reset = 1'b0;
    #1;
    chk("rst_d_gnt",    {31'b0, d_gnt},    32'h0);
    chk("rst_d_rvalid", {31'b0, d_rvalid}, 32'h0);
    chk("rst_m_en",     {31'b0, m_en},     32'h0);
    chk("rst_m_addr",   m_addr,            32'h0);
    @(posedge clk); #1;
    chk("rst_hold_d_gnt", {31'b0, d_gnt}, 32'h0);
    c_req = 1'b0; d_req = 1'b0; d_lock = 1'b0;
    reset = 1'b1;
    apply(idle);
    apply(idle);

    // both req after reset: IDLE + starve_cnt 0 means C, C, C, D, ...
    for (int i = 0; i < 10; i++)
      apply(mk(1,4'h0,32'h700,32'h0, 1,4'h0,32'h800,32'h0, 0,
               (i % 4) != 3, (i % 4) == 3));
    apply(idle);
    chk("sb_drained_end", sb.size(), 32'd0);
`ifdef ARB_STATS_EN
    chk("stat_conflict_cnt", stat_conflict_cnt, 32'd10);
    chk("stat_c_cnt",        stat_c_cnt,        32'd8);
    chk("stat_d_cnt",        stat_d_cnt,        32'd2);
    chk("stat_sum",          stat_c_cnt + stat_d_cnt, 32'd10);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
